// File: rtl/breakout_pkg.sv
// Shared definitions for the Breakout round controller.
//   round_state_t : round phase encodings, also driven on round_state
//   CNT_W/CNT_MAX : frame counter width and its largest loadable value
//   SPEED_MAX     : ball_speed saturation limit
//   speed_add_sat : saturating ball_speed increment
package breakout_pkg;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = 255;
  localparam logic [3:0]  SPEED_MAX = 4'd15;

  typedef enum logic [2:0] {
    RS_SERVE    = 3'd0,
    RS_PLAY     = 3'd1,
    RS_LOST     = 3'd2,
    RS_LEVEL_UP = 3'd3,
    RS_OVER     = 3'd4,
    RS_WON      = 3'd5
  } round_state_t;

  function automatic logic [3:0] speed_add_sat(input logic [3:0] speed,
                                               input logic [3:0] step);
    logic [4:0] sum;
    sum = {1'b0, speed} + {1'b0, step};
    return (sum > 5'(SPEED_MAX)) ? SPEED_MAX : sum[3:0];
  endfunction

endpackage

// File: rtl/breakout_frame_timer.sv
// Loadable frame-tick down-counter, shared by the pause countdown and the
// serve timeout.
//   clk, reset_btn_n : clock, synchronous active-low reset (count -> 0)
//   load, load_value : load the count (wins over a same-cycle tick)
//   frame_tick       : decrements a non-zero count once per pulse
//   freeze           : holds the count and suppresses done
//   done             : high on the tick that takes the count from 1 to 0
module breakout_frame_timer
  import breakout_pkg::*;
(
  input  logic             clk,
  input  logic             reset_btn_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             frame_tick,
  input  logic             freeze,
  output logic             done
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = frame_tick && !freeze;

  always_ff @(posedge clk) begin
    if (!reset_btn_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_value;
    end else if (w_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // done feeds only the controller's next-state logic, never an output pin.
  assign done = w_tick && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/breakout_round_ctrl.sv
// Breakout round sequencer: serve / play / lost-ball / level-up phases,
// lives and level bookkeeping, physics gating and brick-field reloads.
//   clk, reset_btn_n  : clock, synchronous active-low reset
//   game_reset        : holds the block in its initial state (as reset)
//   game_active       : low freezes the round (state, counters, lives, level)
//   frame_tick        : one pulse per video frame
//   launch_btn        : level-sensitive serve request
//   ball_lost         : pulse, ball passed the paddle
//   bricks_cleared    : pulse, last brick destroyed
//   ball_hold, physics_en, brick_reload, lives, level, ball_speed,
//   game_over_signal, game_won_signal, round_state : registered outputs
// Build option: define BREAKOUT_AUTO_SERVE_EN to auto-launch after
// SERVE_TIMEOUT frame ticks in SERVE.
module breakout_round_ctrl
  import breakout_pkg::*;
#(
  parameter int unsigned NUM_LIVES     = 3,
  parameter int unsigned NUM_LEVELS    = 3,
  parameter int unsigned PAUSE_FRAMES  = 60,
  parameter int unsigned SERVE_TIMEOUT = 180,
  parameter int unsigned SPEED_BASE    = 1,
  parameter int unsigned SPEED_STEP    = 1
) (
  input  logic       clk,
  input  logic       reset_btn_n,
  input  logic       game_reset,
  input  logic       game_active,
  input  logic       frame_tick,
  input  logic       launch_btn,
  input  logic       ball_lost,
  input  logic       bricks_cleared,
  output logic       ball_hold,
  output logic       physics_en,
  output logic       brick_reload,
  output logic [2:0] lives,
  output logic [2:0] level,
  output logic [3:0] ball_speed,
  output logic       game_over_signal,
  output logic       game_won_signal,
  output logic [2:0] round_state
);

  if (NUM_LIVES < 1 || NUM_LIVES > 7) begin : g_bad_lives
    $error("NUM_LIVES must be in 1..7");
  end
  if (NUM_LEVELS < 1 || NUM_LEVELS > 7) begin : g_bad_levels
    $error("NUM_LEVELS must be in 1..7");
  end
  if (PAUSE_FRAMES < 1 || PAUSE_FRAMES > CNT_MAX) begin : g_bad_pause
    $error("PAUSE_FRAMES must be in 1..255");
  end
  if (SERVE_TIMEOUT > CNT_MAX) begin : g_bad_serve
    $error("SERVE_TIMEOUT must not exceed 255");
  end
  if (SPEED_BASE > 15 || SPEED_STEP > 15) begin : g_bad_speed
    $error("SPEED_BASE and SPEED_STEP must not exceed 15");
  end

  round_state_t     r_state;
  round_state_t     w_next;
  logic [2:0]       r_lives;
  logic [2:0]       r_level;
  logic [3:0]       r_speed;
  logic             r_init;
  logic             r_brick_reload;
  logic             r_ball_hold;
  logic             r_physics_en;
  logic             r_over;
  logic             r_won;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_done;
  logic             w_timer_rst_n;

  assign w_timer_rst_n = reset_btn_n && !game_reset;

  breakout_frame_timer u_timer (
    .clk         (clk),
    .reset_btn_n (w_timer_rst_n),
    .load        (w_load),
    .load_value  (w_load_val),
    .frame_tick  (frame_tick),
    .freeze      (!game_active),
    .done        (w_done)
  );

  // Next state and timer loads. The timer is loaded on the transition edge
  // so the first counted tick is the one after entering the new state.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = CNT_W'(PAUSE_FRAMES);
`ifdef BREAKOUT_AUTO_SERVE_EN
    // Reset leaves the timer at zero; arm the serve timeout on the first
    // cycle out of reset.
    if (r_init) begin
      w_load     = 1'b1;
      w_load_val = CNT_W'(SERVE_TIMEOUT);
    end
`endif
    case (r_state)
      RS_SERVE: begin
        if (game_active) begin
          if (launch_btn) begin
            w_next = RS_PLAY;
          end
`ifdef BREAKOUT_AUTO_SERVE_EN
          else if (w_done) begin
            w_next = RS_PLAY;
          end
`endif
        end
      end
      RS_PLAY: begin
        if (game_active) begin
          if (bricks_cleared) begin
            if (r_level == 3'(NUM_LEVELS)) begin
              w_next = RS_WON;
            end else begin
              w_next = RS_LEVEL_UP;
              w_load = 1'b1;
            end
          end else if (ball_lost) begin
            if (r_lives == 3'd1) begin
              w_next = RS_OVER;
            end else begin
              w_next = RS_LOST;
              w_load = 1'b1;
            end
          end
        end
      end
      RS_LOST, RS_LEVEL_UP: begin
        if (w_done) begin
          w_next = RS_SERVE;
`ifdef BREAKOUT_AUTO_SERVE_EN
          w_load     = 1'b1;
          w_load_val = CNT_W'(SERVE_TIMEOUT);
`endif
        end
      end
      RS_OVER, RS_WON: begin
        w_next = r_state;
      end
      default: begin
        w_next = RS_SERVE;
`ifdef BREAKOUT_AUTO_SERVE_EN
        w_load     = 1'b1;
        w_load_val = CNT_W'(SERVE_TIMEOUT);
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_btn_n || game_reset) begin
      r_state        <= RS_SERVE;
      r_lives        <= 3'(NUM_LIVES);
      r_level        <= 3'd1;
      r_speed        <= 4'(SPEED_BASE);
      r_init         <= 1'b1;
      r_brick_reload <= 1'b0;
      r_ball_hold    <= 1'b1;
      r_physics_en   <= 1'b0;
      r_over         <= 1'b0;
      r_won          <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_init         <= 1'b0;
      r_brick_reload <= r_init;
      if (r_state == RS_PLAY && w_next == RS_LEVEL_UP) begin
        r_level        <= r_level + 3'd1;
        r_speed        <= speed_add_sat(r_speed, 4'(SPEED_STEP));
        r_brick_reload <= 1'b1;
      end
      if (r_state == RS_PLAY && (w_next == RS_LOST || w_next == RS_OVER)) begin
        r_lives <= r_lives - 3'd1;
      end
      r_ball_hold  <= (w_next != RS_PLAY);
      r_physics_en <= game_active && (w_next == RS_PLAY);
      r_over       <= (w_next == RS_OVER);
      r_won        <= (w_next == RS_WON);
    end
  end

  assign ball_hold        = r_ball_hold;
  assign physics_en       = r_physics_en;
  assign brick_reload     = r_brick_reload;
  assign lives            = r_lives;
  assign level            = r_level;
  assign ball_speed       = r_speed;
  assign game_over_signal = r_over;
  assign game_won_signal  = r_won;
  assign round_state      = r_state;

endmodule

// File: tb/tb_breakout_round_ctrl.sv
module tb_breakout_round_ctrl;

  localparam logic [2:0] S_SERVE = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_LOST  = 3'd2;
  localparam logic [2:0] S_LVLUP = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;
  localparam logic [2:0] S_WON   = 3'd5;

  logic       clk = 1'b0;
  logic       reset_btn_n = 1'b0;
  logic       game_reset = 1'b0;
  logic       game_active = 1'b1;
  logic       frame_tick = 1'b0;
  logic       launch_btn = 1'b0;
  logic       ball_lost = 1'b0;
  logic       bricks_cleared = 1'b0;
  logic       ball_hold, physics_en, brick_reload;
  logic [2:0] lives, level, round_state;
  logic [3:0] ball_speed;
  logic       game_over_signal, game_won_signal;

  always #5 clk = ~clk;

  breakout_round_ctrl #(
    .NUM_LIVES     (3),
    .NUM_LEVELS    (3),
    .PAUSE_FRAMES  (60),
    .SERVE_TIMEOUT (4),
    .SPEED_BASE    (1),
    .SPEED_STEP    (1)
  ) dut (
    .clk              (clk),
    .reset_btn_n      (reset_btn_n),
    .game_reset       (game_reset),
    .game_active      (game_active),
    .frame_tick       (frame_tick),
    .launch_btn       (launch_btn),
    .ball_lost        (ball_lost),
    .bricks_cleared   (bricks_cleared),
    .ball_hold        (ball_hold),
    .physics_en       (physics_en),
    .brick_reload     (brick_reload),
    .lives            (lives),
    .level            (level),
    .ball_speed       (ball_speed),
    .game_over_signal (game_over_signal),
    .game_won_signal  (game_won_signal),
    .round_state      (round_state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] lives;
    logic [2:0] level;
    logic [3:0] speed;
    logic       hold;
    logic       phys;
    logic       reload;
    logic       over;
    logic       won;
  } exp_t;

  typedef struct {
    exp_t  e;
    string nm;
  } sb_t;

  typedef struct {
    logic  launch, bl, bc, act, tk;
    exp_t  e;
    string nm;
  } vec_t;

  sb_t         sb_q[$];
  vec_t        tbl[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Expected lives/level/speed, updated by hand as the scenario progresses.
  logic [2:0] lv = 3'd3;
  logic [2:0] lvl = 3'd1;
  logic [3:0] spd = 4'd1;

  function automatic exp_t mk_full(input logic [2:0] st, input logic [2:0] l,
                                   input logic [2:0] v, input logic [3:0] s,
                                   input logic rl, input logic act);
    exp_t e;
    e.st     = st;
    e.lives  = l;
    e.level  = v;
    e.speed  = s;
    e.hold   = (st != S_PLAY);
    e.phys   = (st == S_PLAY) && act;
    e.reload = rl;
    e.over   = (st == S_OVER);
    e.won    = (st == S_WON);
    return e;
  endfunction

  function automatic exp_t mk(input logic [2:0] st, input logic rl);
    return mk_full(st, lv, lvl, spd, rl, game_active);
  endfunction

  function automatic vec_t mkv(input logic l, input logic bl, input logic bc,
                               input exp_t e, input string nm);
    vec_t v;
    v.launch = l; v.bl = bl; v.bc = bc; v.act = 1'b1; v.tk = 1'b0;
    v.e = e; v.nm = nm;
    return v;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a.st = round_state; a.lives = lives; a.level = level; a.speed = ball_speed;
    a.hold = ball_hold; a.phys = physics_en; a.reload = brick_reload;
    a.over = game_over_signal; a.won = game_won_signal;
    return a;
  endfunction

  task automatic step(input exp_t e, input string nm);
    sb_t  s;
    exp_t got;
    s.e = e;
    s.nm = nm;
    sb_q.push_back(s);
    @(posedge clk);
    #1;
    s = sb_q.pop_front();
    got = actual();
    n_vec++;
    if (got !== s.e) begin
      n_err++;
      $display("FAIL %s: got st=%0d lives=%0d level=%0d speed=%0d hold=%b phys=%b reload=%b over=%b won=%b, required st=%0d lives=%0d level=%0d speed=%0d hold=%b phys=%b reload=%b over=%b won=%b",
               s.nm, got.st, got.lives, got.level, got.speed, got.hold, got.phys,
               got.reload, got.over, got.won, s.e.st, s.e.lives, s.e.level,
               s.e.speed, s.e.hold, s.e.phys, s.e.reload, s.e.over, s.e.won);
    end
  endtask

  task automatic set_in(input logic l, input logic bl, input logic bc);
    launch_btn = l;
    ball_lost = bl;
    bricks_cleared = bc;
    frame_tick = 1'b0;
  endtask

  // n frame ticks separated by idle cycles; the last tick leads to fin_st.
  task automatic ticks(input int unsigned n, input logic [2:0] st,
                       input logic [2:0] fin_st, input string nm);
    for (int unsigned i = 1; i <= n; i++) begin
      set_in(1'b0, 1'b0, 1'b0);
      frame_tick = 1'b1;
      step(mk((i == n) ? fin_st : st, 1'b0), nm);
      frame_tick = 1'b0;
      if (i != n) step(mk(st, 1'b0), nm);
    end
  endtask

  task automatic do_reset(input logic use_btn, input string nm);
    set_in(1'b0, 1'b0, 1'b0);
    game_active = 1'b1;
    if (use_btn) reset_btn_n = 1'b0;
    else game_reset = 1'b1;
    lv = 3'd3; lvl = 3'd1; spd = 4'd1;
    step(mk(S_SERVE, 1'b0), nm);
    step(mk(S_SERVE, 1'b0), nm);
    reset_btn_n = 1'b1;
    game_reset = 1'b0;
    step(mk(S_SERVE, 1'b1), {nm, "_reload"});
  endtask

  initial begin
    // Power-on reset, then the table-driven opening of a game.
    do_reset(1'b1, "reset_state");
    tbl.push_back(mkv(0, 0, 0, mk_full(S_SERVE, 3, 1, 1, 0, 1), "reload_once"));
    tbl.push_back(mkv(0, 1, 0, mk_full(S_SERVE, 3, 1, 1, 0, 1), "serve_ignores_lost"));
    tbl.push_back(mkv(1, 0, 0, mk_full(S_PLAY,  3, 1, 1, 0, 1), "launch"));
    tbl.push_back(mkv(0, 0, 0, mk_full(S_PLAY,  3, 1, 1, 0, 1), "play_idle"));
    tbl.push_back(mkv(0, 1, 1, mk_full(S_LVLUP, 3, 2, 2, 1, 1), "cleared_beats_lost"));
    tbl.push_back(mkv(0, 0, 0, mk_full(S_LVLUP, 3, 2, 2, 0, 1), "reload_pulse_ends"));
    tbl.push_back(mkv(1, 1, 1, mk_full(S_LVLUP, 3, 2, 2, 0, 1), "levelup_ignores_inputs"));
    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].launch, tbl[i].bl, tbl[i].bc);
      game_active = tbl[i].act;
      frame_tick = tbl[i].tk;
      step(tbl[i].e, tbl[i].nm);
    end
    lv = 3'd3; lvl = 3'd2; spd = 4'd2;
    ticks(60, S_LVLUP, S_SERVE, "levelup2_pause");
    set_in(1, 0, 0); step(mk(S_PLAY, 0), "launch_l2");
    set_in(0, 0, 1); lvl = 3'd3; spd = 4'd3;
    step(mk(S_LVLUP, 1), "cleared_l2");
    set_in(0, 0, 0); step(mk(S_LVLUP, 0), "reload_l2_ends");
    ticks(60, S_LVLUP, S_SERVE, "levelup3_pause");
    set_in(1, 0, 0); step(mk(S_PLAY, 0), "launch_l3");
    set_in(0, 0, 1); step(mk(S_WON, 0), "cleared_last_level");
    set_in(0, 0, 0); step(mk(S_WON, 0), "won_held");
    set_in(1, 1, 1); step(mk(S_WON, 0), "won_ignores_inputs");

    // Losing every life, with a freeze in PLAY and in LOST.
    do_reset(1'b0, "game_reset_from_won");
    set_in(1, 0, 0); step(mk(S_PLAY, 0), "launch_g2");
    game_active = 1'b0;
    set_in(0, 1, 0); step(mk(S_PLAY, 0), "frozen_play_ignores_lost");
    game_active = 1'b1;
    set_in(0, 0, 0); step(mk(S_PLAY, 0), "unfreeze_play");
    set_in(0, 1, 0); lv = 3'd2; step(mk(S_LOST, 0), "lost_1");
    ticks(30, S_LOST, S_LOST, "lost_pause_a");
    game_active = 1'b0;
    ticks(100, S_LOST, S_LOST, "lost_frozen");
    game_active = 1'b1;
    ticks(30, S_LOST, S_SERVE, "lost_pause_b");
    set_in(1, 0, 0); step(mk(S_PLAY, 0), "launch_after_lost1");
    set_in(0, 1, 0); lv = 3'd1; step(mk(S_LOST, 0), "lost_2");
    ticks(60, S_LOST, S_SERVE, "lost2_pause");
    set_in(1, 0, 0); step(mk(S_PLAY, 0), "launch_after_lost2");
    set_in(0, 1, 0); lv = 3'd0; step(mk(S_OVER, 0), "last_life_over");
    set_in(1, 0, 1); step(mk(S_OVER, 0), "over_held");
    ticks(3, S_OVER, S_OVER, "over_ignores_ticks");

    // game_reset in the middle of a LEVEL_UP pause.
    do_reset(1'b1, "reset_g3");
    set_in(1, 0, 0); step(mk(S_PLAY, 0), "launch_g3");
    set_in(0, 0, 1); lvl = 3'd2; spd = 4'd2;
    step(mk(S_LVLUP, 1), "cleared_g3");
    ticks(10, S_LVLUP, S_LVLUP, "levelup_partial");
    do_reset(1'b0, "game_reset_mid_levelup");

    // Serve timeout behaviour.
    do_reset(1'b1, "reset_g4");
`ifdef BREAKOUT_AUTO_SERVE_EN
    ticks(4, S_SERVE, S_PLAY, "auto_serve");
`else
    ticks(1000, S_SERVE, S_SERVE, "no_auto_serve");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
